// File: rtl/posi_sipo.sv
// Serial-in / parallel-out shift register with an enable-gated, registered output word.
// Optional POSI_BIT_COUNT_EN adds a saturating shifted-bit counter and a `full` flag.
module posi_sipo #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         serial_in,
    input  logic         en_o,
    output logic [n-1:0] parallel_out
`ifdef POSI_BIT_COUNT_EN
    ,
    output logic         full
`endif
);

    logic [n-1:0] mem;
    logic [n-1:0] w_mem_next;

    // A one-bit word has no lower slice to shift, so it just takes the new bit.
    generate
        if (n == 1) begin : g_single
            assign w_mem_next = serial_in;
        end else begin : g_multi
            assign w_mem_next = {mem[n-2:0], serial_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (load) begin
            mem <= w_mem_next;
        end
    end

    // Capture samples the pre-shift mem, since both registers update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parallel_out <= '0;
        end else if (en_o) begin
            parallel_out <= mem;
        end
    end

`ifdef POSI_BIT_COUNT_EN
    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(n);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en_o) begin
            cnt <= load ? CW'(1) : '0;
        end else if (load && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign full = (cnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_posi_sipo.sv
// Self-checking bench for posi_sipo (n=4): directed vector table, async reset sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_posi_sipo;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic         serial_in;
    logic         en_o;
    logic [N-1:0] parallel_out;
`ifdef POSI_BIT_COUNT_EN
    logic         full;
`endif

    int checkCount;
    int passCount;

    typedef struct {
        logic       load;
        logic       serialIn;
        logic       enO;
        logic [3:0] expOut;
        logic [3:0] expMem;
        logic       expFull;
    } vector_t;

    vector_t vectors[$];

    posi_sipo #(.n(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .serial_in    (serial_in),
        .en_o         (en_o),
        .parallel_out (parallel_out)
`ifdef POSI_BIT_COUNT_EN
        ,
        .full         (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample just after the rising edge.
    task automatic applyStimulus(input logic ld, input logic si, input logic en);
        @(negedge clk);
        load      = ld;
        serial_in = si;
        en_o      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic ld, input logic si, input logic en,
                          input logic [3:0] eo, input logic [3:0] em, input logic ef);
        vector_t v;
        v.load = ld; v.serialIn = si; v.enO = en;
        v.expOut = eo; v.expMem = em; v.expFull = ef;
        vectors.push_back(v);
    endtask

    int modelMem;
    int modelOut;
    int modelCnt;
    int bitIn;
    int ldIn;
    int enIn;

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Shift 1,0,1,1 with output disabled
        addVec(1, 1, 0, 4'b0000, 4'b0001, 0);
        addVec(1, 0, 0, 4'b0000, 4'b0010, 0);
        addVec(1, 1, 0, 4'b0000, 4'b0101, 0);
        addVec(1, 1, 0, 4'b0000, 4'b1011, 1);
        // Capture, then hold
        addVec(0, 0, 1, 4'b1011, 4'b1011, 0);
        addVec(0, 0, 0, 4'b1011, 4'b1011, 0);
        addVec(0, 1, 0, 4'b1011, 4'b1011, 0);
        // Overrun: 1,1,0,0,1 then capture
        addVec(1, 1, 0, 4'b1011, 4'b0111, 0);
        addVec(1, 1, 0, 4'b1011, 4'b1111, 0);
        addVec(1, 0, 0, 4'b1011, 4'b1110, 0);
        addVec(1, 0, 0, 4'b1011, 4'b1100, 1);
        addVec(1, 1, 0, 4'b1011, 4'b1001, 1);
        addVec(0, 0, 1, 4'b1001, 4'b1001, 0);
        // Rebuild 1011, then simultaneous shift and capture
        addVec(1, 1, 0, 4'b1001, 4'b0011, 0);
        addVec(1, 0, 0, 4'b1001, 4'b0110, 0);
        addVec(1, 1, 0, 4'b1001, 4'b1101, 0);
        addVec(1, 1, 0, 4'b1001, 4'b1011, 1);
        addVec(1, 0, 1, 4'b1011, 4'b0110, 0);

        // Reset asserted at time zero, with active-looking inputs
        rst       = 1'b0;
        load      = 1'b1;
        serial_in = 1'b1;
        en_o      = 1'b1;
        #1;
        checkOutput("reset_out_t0", 32'(parallel_out), 32'd0);
        checkOutput("reset_mem_t0", 32'(dut.mem), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_out_held", 32'(parallel_out), 32'd0);
        checkOutput("reset_mem_held", 32'(dut.mem), 32'd0);
`ifdef POSI_BIT_COUNT_EN
        checkOutput("reset_full_held", 32'(full), 32'd0);
`endif
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        en_o = 1'b0;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].load, vectors[i].serialIn, vectors[i].enO);
            checkOutput($sformatf("vec%0d_out", i), 32'(parallel_out), 32'(vectors[i].expOut));
            checkOutput($sformatf("vec%0d_mem", i), 32'(dut.mem), 32'(vectors[i].expMem));
`ifdef POSI_BIT_COUNT_EN
            checkOutput($sformatf("vec%0d_full", i), 32'(full), 32'(vectors[i].expFull));
`endif
        end

        // Get parallel_out to 1011 with mem also full, then reset between edges
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("pre_reset_out", 32'(parallel_out), 32'b1011);
        checkOutput("pre_reset_mem", 32'(dut.mem), 32'b1011);
        @(negedge clk);
        load = 1'b1;
        en_o = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_out", 32'(parallel_out), 32'd0);
        checkOutput("async_reset_mem", 32'(dut.mem), 32'd0);
`ifdef POSI_BIT_COUNT_EN
        checkOutput("async_reset_full", 32'(full), 32'd0);
`endif
        @(posedge clk);
        #1;
        checkOutput("reset_low_edge_out", 32'(parallel_out), 32'd0);
        checkOutput("reset_low_edge_mem", 32'(dut.mem), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        en_o = 1'b0;

        // Partial word after reset: only the new bits are present
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 1);
        checkOutput("post_reset_partial_out", 32'(parallel_out), 32'b0001);
        checkOutput("post_reset_partial_mem", 32'(dut.mem), 32'b0011);

        // Randomized traffic against a value-level model of the word
        modelMem = 3;
        modelOut = 1;
        modelCnt = 1;
        for (int c = 0; c < 300; c++) begin
            ldIn  = int'($urandom_range(0, 1));
            bitIn = int'($urandom_range(0, 1));
            enIn  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            applyStimulus(ldIn[0], bitIn[0], enIn[0]);
            if (enIn == 1) modelOut = modelMem;
            if (ldIn == 1) modelMem = (modelMem * 2 + bitIn) % (1 << N);
            if (enIn == 1) modelCnt = ldIn;
            else if (ldIn == 1 && modelCnt < N) modelCnt = modelCnt + 1;
            checkOutput($sformatf("rand%0d_out", c), 32'(parallel_out), 32'(modelOut));
            checkOutput($sformatf("rand%0d_mem", c), 32'(dut.mem), 32'(modelMem));
`ifdef POSI_BIT_COUNT_EN
            checkOutput($sformatf("rand%0d_full", c), 32'(full), (modelCnt == N) ? 32'd1 : 32'd0);
`endif
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
